// File: rtl/fn_suma_resta_sync_if.sv
// Operand/result bundle for the registered RV32I add/subtract unit.
// The slave modport is the ALU side; the master modport is the issuing side.
interface fn_suma_resta_sync_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resta;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a, b, resta,
    input  Y, out_valid, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a, b, resta,
    output Y, out_valid, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/fn_suma_resta_sync.sv
// Registered two's-complement adder/subtractor (ADD/SUB/ADDI), one-cycle latency.
// Status flags are built only when FN_SUMA_RESTA_FLAGS_EN is defined; otherwise tied to 0.
module fn_suma_resta_sync #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fn_suma_resta_sync_if.slave  bus
);

  // Subtract reuses the adder: a + ~b + 1
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_cin;

  assign w_bb  = bus.b ^ {WIDTH{bus.resta}};
  assign w_cin = {{(WIDTH-1){1'b0}}, bus.resta};

  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;

`ifdef FN_SUMA_RESTA_FLAGS_EN
  logic [WIDTH:0]   w_sum;
  logic             w_v;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;

  assign w_sum = {1'b0, bus.a} + {1'b0, w_bb} + {1'b0, w_cin};
  assign w_v   = (bus.a[WIDTH-1] == w_bb[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_y      <= w_sum[WIDTH-1:0];
        r_flag_z <= (w_sum[WIDTH-1:0] == '0);
        r_flag_n <= w_sum[WIDTH-1];
        r_flag_c <= w_sum[WIDTH];
        r_flag_v <= w_v;
      end
    end
  end

  assign bus.flag_z = r_flag_z;
  assign bus.flag_n = r_flag_n;
  assign bus.flag_c = r_flag_c;
  assign bus.flag_v = r_flag_v;
`else
  logic [WIDTH-1:0] w_sum;

  assign w_sum = bus.a + w_bb + w_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_y <= w_sum;
      end
    end
  end

  assign bus.flag_z = 1'b0;
  assign bus.flag_n = 1'b0;
  assign bus.flag_c = 1'b0;
  assign bus.flag_v = 1'b0;
`endif

  assign bus.Y         = r_y;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_fn_suma_resta_sync.sv
// Directed-vector bench for fn_suma_resta_sync; flag expectations follow FN_SUMA_RESTA_FLAGS_EN.
module tb_fn_suma_resta_sync;

`ifdef FN_SUMA_RESTA_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fn_suma_resta_sync_if #(.WIDTH(32)) bus ();

  fn_suma_resta_sync #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        resta;
    logic [31:0] y;
    logic [3:0]  f;   // {z, n, c, v}
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_flags(input logic [3:0] f);
    return FLAGS_EN ? {28'd0, f} : 32'd0;
  endfunction

  function automatic logic [31:0] obs_flags();
    return {28'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.resta    = r;
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    chk({tag, ".y"},     bus.Y, e.y);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".flags"}, obs_flags(), exp_flags(e.f));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{32'd15,        32'd10,        1'b0, 32'd25,        4'b0000};
    vecs[1] = '{32'd15,        32'd10,        1'b1, 32'd5,         4'b0010};
    vecs[2] = '{32'd10,        32'd15,        1'b1, 32'hFFFFFFFB,  4'b0100};
    vecs[3] = '{32'h7FFFFFFF,  32'd1,         1'b0, 32'h80000000,  4'b0101};
    vecs[4] = '{32'h80000000,  32'd1,         1'b1, 32'h7FFFFFFF,  4'b0011};
    vecs[5] = '{32'h00001234,  32'h00001234,  1'b1, 32'd0,         4'b1010};
    vecs[6] = '{32'd0,         32'd1,         1'b1, 32'hFFFFFFFF,  4'b0100};

    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst.y",     bus.Y, 32'd0);
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.flags", obs_flags(), 32'd0);
    rst = 1'b0;

    // back-to-back issue: each negedge checks the previous op and drives the next
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].resta);
      @(negedge clk);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // wrap: 0xFFFFFFFF + 1
    drive(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0);
    @(negedge clk);
    check_vec("wrap", '{32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 4'b1010});

    // idle cycles: Y and flags hold, out_valid drops
    drive(1'b0, 32'h55555555, 32'h12345678, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("idle.y",     bus.Y, 32'd0);
      chk("idle.valid", {31'd0, bus.out_valid}, 32'd0);
      chk("idle.flags", obs_flags(), exp_flags(4'b1010));
    end

    // op accepted just before reset still shows; reset with in_valid=1 discards
    drive(1'b1, vecs[2].a, vecs[2].b, vecs[2].resta);
    @(negedge clk);
    check_vec("pre_rst", vecs[2]);
    rst = 1'b1;
    drive(1'b1, 32'd15, 32'd10, 1'b0);
    @(negedge clk);
    chk("rst_iv.y",     bus.Y, 32'd0);
    chk("rst_iv.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_iv.flags", obs_flags(), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("post_rst.valid", {31'd0, bus.out_valid}, 32'd0);

    drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].resta);
    @(negedge clk);
    check_vec("again", vecs[0]);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("end.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("end.y",     bus.Y, 32'd25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
